// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller.
//   state_t    : controller FSM encoding (IDLE / RUN / DONE)
//   bit_cycles : length of one bit window for a given adder settle latency
//   BIT_CYC    : bit window length for the default adder latency
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // One window per bit: FA_LAT edges to settle plus the sampling edge.
  function automatic int bit_cycles(input int fa_lat);
    return fa_lat + 1;
  endfunction

  localparam int FA_LAT_DEFAULT = 3;
  localparam int BIT_CYC        = bit_cycles(FA_LAT_DEFAULT);

endpackage

// File: rtl/serial_add_ctrl.sv
// Bit-serial sequencer driving one shared synchronous full adder (sync_FA,
// instantiated in the parent) to perform a W-bit addition, LSB first.
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   in_valid/in_ready            operand handshake (ready only in IDLE)
//   in_a, in_b, in_cin           operands and carry-in
//   fa_a, fa_b, fa_cin           adder inputs, held for a whole bit window
//   fa_sum, fa_cout              adder outputs, sampled at end of window
//   out_valid/out_ready          result handshake (valid only in DONE)
//   out_sum, out_cout            W-bit sum and final carry
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int W      = 8,
  parameter int FA_LAT = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_cin,
  output logic         fa_a,
  output logic         fa_b,
  output logic         fa_cin,
  input  logic         fa_sum,
  input  logic         fa_cout,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_sum,
  output logic         out_cout
);

  localparam int WIN_CYC = bit_cycles(FA_LAT);
  localparam int KW      = $clog2(W);
  localparam int CW      = (WIN_CYC > 1) ? $clog2(WIN_CYC) : 1;

  localparam logic [KW-1:0] K_LAST = KW'(W - 1);
  localparam logic [CW-1:0] W_END  = CW'(FA_LAT);

  state_t state, state_nxt;

  logic [KW-1:0] k;        // bit index
  logic [CW-1:0] w;        // cycle within current bit window
  logic [W-1:0]  a_reg;
  logic [W-1:0]  b_reg;
  logic [W-2:0]  sum_reg;  // bits 0..W-2; bit W-1 goes straight to out_sum
  logic          carry;

  logic accept;
  logic bit_end;
  logic last_bit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    fa_a      = 1'b0;
    fa_b      = 1'b0;
    fa_cin    = 1'b0;
    bit_end   = 1'b0;
    last_bit  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        // Adder inputs come from registers that only move at a window
        // boundary, so they are stable for the full window.
        fa_a     = a_reg[k];
        fa_b     = b_reg[k];
        fa_cin   = carry;
        bit_end  = (w == W_END);
        last_bit = bit_end && (k == K_LAST);
        if (last_bit) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    accept = in_ready && in_valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k        <= '0;
      w        <= '0;
      a_reg    <= '0;
      b_reg    <= '0;
      sum_reg  <= '0;
      carry    <= 1'b0;
      out_sum  <= '0;
      out_cout <= 1'b0;
    end else if (accept) begin
      a_reg <= in_a;
      b_reg <= in_b;
      carry <= in_cin;
      k     <= '0;
      w     <= '0;
    end else if (state == RUN) begin
      if (bit_end) begin
        w     <= '0;
        carry <= fa_cout;
        if (last_bit) begin
          out_sum  <= {fa_sum, sum_reg};
          out_cout <= fa_cout;
        end else begin
          sum_reg[k] <= fa_sum;
          k          <= k + 1'b1;
        end
      end else begin
        w <= w + 1'b1;
      end
    end
  end

endmodule
